// File: rtl/wvb_dpram_drain_if.sv
// Bundle of the waveform-buffer DPRAM drain signals.
//
// Groups the reader handshake (dpram_run/len/busy/mode), the readout DPRAM read port
// (rd_addr/rd_data), the host-side 16-bit valid/ready stream (out_*), and the control and
// status lines (en, cfg_mode, done, err_*).
//
// Modports:
//   slave  - the drain itself: responds to dpram_run, reads the DPRAM, drives the stream.
//   master - the surrounding system: reader, DPRAM and stream sink.
interface wvb_dpram_drain_if #(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 8,
  parameter int unsigned P_LEN_WIDTH       = 16
);
  logic                         en;
  logic                         cfg_mode;
  logic                         dpram_run;
  logic [P_LEN_WIDTH-1:0]       dpram_len;
  logic                         dpram_busy;
  logic                         dpram_mode;
  logic [P_DPRAM_ADR_WIDTH-1:0] rd_addr;
  logic [127:0]                 rd_data;
  logic [15:0]                  out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic                         done;
  logic                         err_overrun;
  logic                         err_len;

  modport slave (
    input  en, cfg_mode, dpram_run, dpram_len, rd_data, out_ready,
    output dpram_busy, dpram_mode, rd_addr, out_data, out_valid, out_last, done,
           err_overrun, err_len
  );

  modport master (
    output en, cfg_mode, dpram_run, dpram_len, rd_data, out_ready,
    input  dpram_busy, dpram_mode, rd_addr, out_data, out_valid, out_last, done,
           err_overrun, err_len
  );
endinterface

// File: rtl/wvb_dpram_drain.sv
// Consumer end of the waveform-buffer readout DPRAM handshake.
//
// On a dpram_run pulse the block latches the transfer length (clamped to the DPRAM
// capacity of 8*2^P_DPRAM_ADR_WIDTH words), raises dpram_busy, fetches 128-bit lines from
// the DPRAM (1-cycle read latency) and serialises each line LSB-first into 16-bit words
// on a valid/ready stream. dpram_busy drops and done pulses after the last word.
//
// Ports:
//   clk     - clock
//   rst     - synchronous, active-high reset (bus_io.en low behaves identically)
//   bus_io  - wvb_dpram_drain_if.slave: reader handshake, DPRAM read port, output stream,
//             sticky error flags
//
// Build option:
//   WVB_DPRAM_DRAIN_PREFETCH_EN - adds a 128-bit hold register so the next line is read
//   while the current one is shifted out, removing the 2-cycle bubble between lines.
module wvb_dpram_drain #(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 8,
  parameter int unsigned P_LEN_WIDTH       = 16
) (
  input logic               clk,
  input logic               rst,
  wvb_dpram_drain_if.slave  bus_io
);

  typedef logic [P_LEN_WIDTH-1:0]       len_t;
  typedef logic [P_DPRAM_ADR_WIDTH-1:0] adr_t;

  localparam longint unsigned CapWords = 64'd8 << P_DPRAM_ADR_WIDTH;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StDone} state_e;

  state_e       state_q, state_d;
  logic         busy_q, busy_d;
  logic         mode_q, mode_d;
  adr_t         rd_addr_q, rd_addr_d;
  logic [127:0] shift_q, shift_d;
  logic [3:0]   beats_q, beats_d;       // words still to send from the current line
  len_t         remaining_q, remaining_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         done_q, done_d;
  logic         err_overrun_q, err_overrun_d;
  logic         err_len_q, err_len_d;
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
  logic [127:0] hold_q, hold_d;
  logic         pf1_q, pf1_d;           // prefetch address on the DPRAM port this cycle
  logic         pf2_q, pf2_d;           // prefetch data on rd_data this cycle
`endif

  logic len_over;
  len_t rem_dec;
  logic hs;

  assign len_over = 64'(bus_io.dpram_len) > CapWords;
  assign rem_dec  = remaining_q - len_t'(1);
  assign hs       = out_valid_q && bus_io.out_ready;

  // Words carried by a line given how many words are still owed.
  function automatic logic [3:0] line_beats(len_t rem);
    return (rem >= len_t'(8)) ? 4'd8 : rem[3:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    mode_d        = mode_q;
    rd_addr_d     = rd_addr_q;
    shift_d       = shift_q;
    beats_d       = beats_q;
    remaining_d   = remaining_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    done_d        = 1'b0;
    err_overrun_d = err_overrun_q;
    err_len_d     = err_len_q;
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
    hold_d        = pf2_q ? bus_io.rd_data : hold_q;
    pf1_d         = 1'b0;
    pf2_d         = pf1_q;
`endif

    // A start request outside idle is dropped; latched length/address stay untouched.
    if (bus_io.dpram_run && (state_q != StIdle)) begin
      err_overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        mode_d = bus_io.cfg_mode;
        if (bus_io.dpram_run) begin
          busy_d      = 1'b1;
          rd_addr_d   = '0;
          remaining_d = len_over ? len_t'(CapWords) : bus_io.dpram_len;
          if (len_over) begin
            err_len_d = 1'b1;
          end
          state_d = (bus_io.dpram_len == '0) ? StDone : StFetch;
        end
      end

      // rd_addr is on the DPRAM port; data shows up next cycle.
      StFetch: state_d = StLoad;

      StLoad: begin
        shift_d     = bus_io.rd_data;
        beats_d     = line_beats(remaining_q);
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == len_t'(1));
        state_d     = StShift;
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
        // Issue the next line while this one drains; nothing to fetch on the final line.
        if (remaining_q > len_t'(8)) begin
          rd_addr_d = rd_addr_q + adr_t'(1);
          pf1_d     = 1'b1;
        end
`endif
      end

      StShift: begin
        if (hs) begin
          remaining_d = rem_dec;
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = StDone;
          end else if (beats_q == 4'd1) begin
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
            // Hold was filled long before the 8th beat, so the stream never gaps.
            shift_d    = hold_q;
            beats_d    = line_beats(rem_dec);
            out_last_d = (rem_dec == len_t'(1));
            if (rem_dec > len_t'(8)) begin
              rd_addr_d = rd_addr_q + adr_t'(1);
              pf1_d     = 1'b1;
            end
`else
            rd_addr_d   = rd_addr_q + adr_t'(1);
            out_valid_d = 1'b0;
            state_d     = StFetch;
`endif
          end else begin
            shift_d    = {16'h0000, shift_q[127:16]};
            beats_d    = beats_q - 4'd1;
            out_last_d = (rem_dec == len_t'(1));
          end
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !bus_io.en) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      mode_q        <= 1'b0;
      rd_addr_q     <= '0;
      shift_q       <= '0;
      beats_q       <= '0;
      remaining_q   <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
      err_overrun_q <= 1'b0;
      err_len_q     <= 1'b0;
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
      hold_q        <= '0;
      pf1_q         <= 1'b0;
      pf2_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      mode_q        <= mode_d;
      rd_addr_q     <= rd_addr_d;
      shift_q       <= shift_d;
      beats_q       <= beats_d;
      remaining_q   <= remaining_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
      err_overrun_q <= err_overrun_d;
      err_len_q     <= err_len_d;
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
      hold_q        <= hold_d;
      pf1_q         <= pf1_d;
      pf2_q         <= pf2_d;
`endif
    end
  end

  assign bus_io.dpram_busy  = busy_q;
  assign bus_io.dpram_mode  = mode_q;
  assign bus_io.rd_addr     = rd_addr_q;
  assign bus_io.out_data    = shift_q[15:0];
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.out_last    = out_last_q;
  assign bus_io.done        = done_q;
  assign bus_io.err_overrun = err_overrun_q;
  assign bus_io.err_len     = err_len_q;

endmodule

// File: tb/tb_wvb_dpram_drain.sv
`timescale 1ns/1ps
module tb_wvb_dpram_drain;

  localparam int unsigned AdrW = 8;
  localparam int unsigned LenW = 16;
  localparam int          Cap  = 8 << AdrW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wvb_dpram_drain_if #(.P_DPRAM_ADR_WIDTH(AdrW), .P_LEN_WIDTH(LenW)) bus ();

  wvb_dpram_drain #(.P_DPRAM_ADR_WIDTH(AdrW), .P_LEN_WIDTH(LenW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // DPRAM model: 1-cycle registered read.
  logic [127:0] mem [256];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  exp_err_ovr = 0;
  bit  exp_err_len = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word i of a transfer is 16-bit slice (i mod 8) of line i/8.
  function automatic logic [15:0] exp_word(int i);
    logic [127:0] line;
    line = mem[i / 8];
    return line[(i % 8) * 16 +: 16];
  endfunction

  // Cycle (relative to run at cycle 0) of word i's handshake with ready held high.
  function automatic int hs_cyc(int i);
`ifdef WVB_DPRAM_DRAIN_PREFETCH_EN
    return 3 + i;
`else
    return 3 + i + 2 * (i / 8);
`endif
  endfunction

  // rmode: 0 ready always high, 1 random ready, 2 stall 5 cycles on word 1.
  task automatic xfer(input int len_req, input int rmode, input bit pulse, input int abort_at,
                      input bit abort_en);
    int exp_len, cyc, nhs, last_cyc, stall, budget;
    bit fin, mode_run, pulsed, eb, ed, r;
    exp_len = (len_req > Cap) ? Cap : len_req;
    @(negedge clk);
    mode_run = 1'($urandom_range(0, 1));
    bus.cfg_mode  = mode_run;
    bus.dpram_len = LenW'(len_req);
    bus.dpram_run = 1'b1;
    bus.out_ready = 1'b1;
    if (len_req > Cap) exp_err_len = 1;
    cyc = 0; nhs = 0; last_cyc = -10; stall = 0; fin = 0; pulsed = 0;
    budget = 8 * exp_len + 40;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus.dpram_run = 1'b0;
      bus.dpram_len = LenW'($urandom);
      bus.cfg_mode  = 1'($urandom_range(0, 1));
      if (cyc == 1 && exp_len > 0) chk("rd_addr_first", bus.rd_addr, 0);
      eb = (exp_len == 0) ? (cyc == 1) : ((nhs < exp_len) || (cyc == last_cyc + 1));
      ed = (exp_len == 0) ? (cyc == 2) : ((nhs == exp_len) && (cyc == last_cyc + 2));
      chk("busy", bus.dpram_busy, eb);
      chk("done", bus.done, ed);
      if (eb) chk("mode_held", bus.dpram_mode, mode_run);
      if (nhs >= exp_len) chk("no_extra_valid", bus.out_valid, 0);
      if (rmode == 0 && nhs < exp_len) chk("valid_timing", bus.out_valid, cyc == hs_cyc(nhs));

      if (abort_at >= 0 && nhs == abort_at && bus.out_valid) begin
        bus.out_ready = 1'b0;
        if (abort_en) bus.en = 1'b0;
        else rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.dpram_busy, 0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_last", bus.out_last, 0);
        chk("abort_data", bus.out_data, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_addr", bus.rd_addr, 0);
        chk("abort_err_ovr", bus.err_overrun, 0);
        chk("abort_err_len", bus.err_len, 0);
        rst = 1'b0;
        bus.en = 1'b1;
        exp_err_ovr = 0;
        exp_err_len = 0;
        fin = 1;
      end else begin
        if (rmode == 0) r = 1;
        else if (rmode == 1) r = 1'($urandom_range(0, 1));
        else if (bus.out_valid && nhs == 1 && stall < 5) begin
          r = 0;
          stall++;
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, exp_word(1));
        end else r = 1;
        bus.out_ready = r;
        if (pulse && !pulsed && nhs == 3 && bus.out_valid) begin
          bus.dpram_run = 1'b1;
          pulsed = 1;
          exp_err_ovr = 1;
        end
        if (bus.out_valid && r) begin
          chk("data", bus.out_data, exp_word(nhs));
          chk("last", bus.out_last, nhs == exp_len - 1);
          nhs++;
          if (nhs == exp_len) last_cyc = cyc;
        end
        if ((exp_len == 0) ? (cyc >= 3) : (nhs == exp_len && cyc >= last_cyc + 3)) fin = 1;
        else if (cyc > budget) begin
          chk("cycle_budget_words", nhs, exp_len);
          fin = 1;
        end
      end
    end
    if (abort_at < 0) begin
      chk("hs_count", nhs, exp_len);
      chk("err_len", bus.err_len, exp_err_len);
      chk("err_overrun", bus.err_overrun, exp_err_ovr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1;
    bus.en = 1'b1;
    bus.cfg_mode = 1'b0;
    bus.dpram_run = 1'b0;
    bus.dpram_len = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.dpram_busy, 0);
    chk("rst_mode", bus.dpram_mode, 0);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_ovr", bus.err_overrun, 0);
    chk("rst_err_len", bus.err_len, 0);
    rst = 1'b0;

    xfer(8, 0, 0, -1, 0);
    xfer(11, 0, 0, -1, 0);
    xfer(16, 0, 0, -1, 0);
    xfer(4, 2, 0, -1, 0);
    xfer(0, 0, 0, -1, 0);
    xfer(3000, 0, 0, -1, 0);
    xfer(8, 0, 1, -1, 0);
    xfer(20, 0, 0, 5, 0);
    for (int k = 0; k < 6; k++) xfer($urandom_range(1, 40), 1, 0, -1, 0);
    xfer(30, 1, 1, -1, 0);
    xfer(12, 0, 0, 9, 1);
    xfer(9, 0, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
